// File: rtl/fir_inverse.sv
// Inverse 3-tap FIR: recovers x[n] = (y[n] - B1*x[n-1] - B2*x[n-2]) / B0
// using a 16-cycle restoring divider behind a start/busy/done handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; y_in captured on the accepting edge
// CALC   | forms the signed numerator, loads dividend, counter := 15
// DIV    | one restoring-division step per cycle, quotient MSB first
// DONE   | clamps quotient, updates x_out/err/history, pulses done
module fir_inverse #(
  parameter int unsigned B0 = 20,
  parameter int unsigned B1 = 15,
  parameter int unsigned B2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] y_in,
  output logic [7:0]  x_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] B0_W = 16'(B0);
  localparam logic [15:0] B1_W = 16'(B1);
  localparam logic [15:0] B2_W = 16'(B2);

  state_t      state_q, state_d;
  logic [15:0] y_q, y_d;
  logic [7:0]  x1_q, x1_d;
  logic [7:0]  x2_q, x2_d;
  logic [15:0] work_q, work_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [7:0]  x_out_q, x_out_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0]        prod1, prod2;
  logic signed [17:0] num;
  logic [16:0]        rem_t;
  logic [16:0]        rem_diff;
  logic               rem_ge;
  logic               q_ovf;
  logic [7:0]         x_new;
  logic               err_new;
  logic               unused_bits;

  // Products fit in 16 bits for 8-bit coefficients and 8-bit history
  assign prod1 = B1_W * {8'd0, x1_q};
  assign prod2 = B2_W * {8'd0, x2_q};
  assign num   = $signed({2'b00, y_q}) - $signed({2'b00, prod1})
               - $signed({2'b00, prod2});

  // work_q holds the dividend shifting out the top and the quotient
  // shifting in the bottom; after 16 steps it is the full quotient.
  assign rem_t    = {rem_q, work_q[15]};
  assign rem_ge   = (rem_t >= {1'b0, B0_W});
  assign rem_diff = rem_t - {1'b0, B0_W};

  assign q_ovf   = |work_q[15:8];
  assign x_new   = neg_q ? 8'd0 : (q_ovf ? 8'hFF : work_q[7:0]);
  assign err_new = neg_q | q_ovf | (rem_q != 16'd0);

  // A non-negative numerator never exceeds 16 bits; remainder is below B0
  assign unused_bits = ^{num[16], rem_diff[16]};

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    work_d  = work_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    x_out_d = x_out_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d     = y_in;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        neg_d   = num[17];
        work_d  = num[17] ? 16'd0 : num[15:0];
        rem_d   = 16'd0;
        cnt_d   = 4'd15;
        state_d = S_DIV;
      end
      S_DIV: begin
        if (rem_ge) begin
          rem_d  = rem_diff[15:0];
          work_d = {work_q[14:0], 1'b1};
        end else begin
          rem_d  = rem_t[15:0];
          work_d = {work_q[14:0], 1'b0};
        end
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        x_out_d = x_new;
        err_d   = err_new;
        x2_d    = x1_q;
        x1_d    = x_new;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= 16'd0;
      x1_q    <= 8'd0;
      x2_q    <= 8'd0;
      work_q  <= 16'd0;
      rem_q   <= 16'd0;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      x_out_q <= 8'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      x_out_q <= x_out_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x_out = x_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_fir_inverse.sv
// Bench for fir_inverse: directed vector table, multi-cycle corner cases,
// and randomized operations checked against an arithmetic reference model.
module tb_fir_inverse;

  localparam int B0 = 20;
  localparam int B1 = 15;
  localparam int B2 = 10;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] y_in;
  logic [7:0]  x_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int m_x1    = 0;
  int m_x2    = 0;

  fir_inverse #(.B0(B0), .B1(B1), .B2(B2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .y_in  (y_in),
    .x_out (x_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit rst_before;
    int y;
    int exp_x;
    int exp_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: x = floor(num / B0) clamped to 0..255, with history of clamped values
  function automatic void model_step(input int y, output int ex, output int ee);
    int num, q, r;
    num = y - B1 * m_x1 - B2 * m_x2;
    if (num < 0) begin
      ex = 0;
      ee = 1;
    end else begin
      q  = num / B0;
      r  = num % B0;
      ex = (q > 255) ? 255 : q;
      ee = (q > 255 || r != 0) ? 1 : 0;
    end
    m_x2 = m_x1;
    m_x1 = ex;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_x1 = 0;
    m_x2 = 0;
  endtask

  task automatic run_op(input int y, output int gx, output int ge,
                        output int lat, output int bc);
    @(negedge clk);
    y_in  = 16'(y);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc  = busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bc++;
    end
    gx = int'(x_out);
    ge = int'(err);
  endtask

  vec_t vecs[7];
  int gx, ge, lat, bc, ex, ee;
  int t_done[3];
  int ys[3];
  int seen;
  int ndone;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    y_in  = 16'd0;

    vecs[0] = '{0, 200,  10,  0};
    vecs[1] = '{0, 230,  4,   0};
    vecs[2] = '{0, 5260, 255, 0};
    vecs[3] = '{0, 100,  0,   1};
    vecs[4] = '{1, 6000, 255, 1};
    vecs[5] = '{1, 205,  10,  1};
    vecs[6] = '{0, 150,  0,   0};

    #12;
    chk("reset x_out", int'(x_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_op(vecs[i].y, gx, ge, lat, bc);
      model_step(vecs[i].y, ex, ee);
      chk($sformatf("vec%0d latency", i), lat, 18);
      chk($sformatf("vec%0d busy cycles", i), bc, 18);
      chk($sformatf("vec%0d x_out", i), gx, vecs[i].exp_x);
      chk($sformatf("vec%0d err", i), ge, vecs[i].exp_err);
    end

    // Extra start mid-operation must be ignored
    do_reset();
    @(negedge clk);
    y_in  = 16'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    y_in  = 16'd999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    model_step(200, ex, ee);
    chk("ignored start done seen", seen, 1);
    chk("ignored start x_out", int'(x_out), 10);
    chk("ignored start err", int'(err), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("x_out held", int'(x_out), 10);
    chk("busy idle after ignored start", int'(busy), 0);

    // start held high: three back-to-back operations
    for (int i = 0; i < 3; i++) ys[i] = $urandom_range(0, 12000);
    @(negedge clk);
    y_in  = 16'(ys[0]);
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 100 && ndone < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        t_done[ndone] = cyc;
        model_step(ys[ndone], ex, ee);
        chk($sformatf("held op%0d x_out", ndone), int'(x_out), ex);
        chk($sformatf("held op%0d err", ndone), int'(err), ee);
        ndone++;
        if (ndone < 3) y_in = 16'(ys[ndone]);
        else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held done count", ndone, 3);
    if (ndone == 3) begin
      chk("held spacing 1", t_done[1] - t_done[0], 19);
      chk("held spacing 2", t_done[2] - t_done[1], 19);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("busy low after held", int'(busy), 0);

    // Asynchronous reset during DIV
    do_reset();
    run_op(230, gx, ge, lat, bc);
    model_step(230, ex, ee);
    chk("pre-reset x_out", gx, 11);
    chk("pre-reset err", ge, 1);
    @(negedge clk);
    y_in  = 16'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst x_out", int'(x_out), 0);
    chk("async rst err", int'(err), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    m_x1 = 0;
    m_x2 = 0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("no done after async rst", seen, 0);
    run_op(200, gx, ge, lat, bc);
    model_step(200, ex, ee);
    chk("post-rst x_out", gx, 10);
    chk("post-rst err", ge, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      int y;
      case ($urandom_range(0, 2))
        0: y = B0 * $urandom_range(0, 255) + B1 * m_x1 + B2 * m_x2;
        1: y = B1 * m_x1 + B2 * m_x2 + $urandom_range(0, 400) - 200;
        default: y = $urandom_range(0, 65535);
      endcase
      if (y < 0) y = 0;
      if (y > 65535) y = 65535;
      run_op(y, gx, ge, lat, bc);
      model_step(y, ex, ee);
      chk($sformatf("rand%0d y=%0d latency", i, y), lat, 18);
      chk($sformatf("rand%0d y=%0d x_out", i, y), gx, ex);
      chk($sformatf("rand%0d y=%0d err", i, y), ge, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fir_inverse.md
Name: fir_inverse

Overview:
- Inverse (deconvolving) counterpart of the team's 3-tap FIR filter. Given successive filter outputs y[n], it recovers the original 8-bit input samples x[n].
- Uses x[n] = (y[n] - b1*x[n-1] - b2*x[n-2]) / b0.
- Divides with a multi-cycle restoring divider under a start/busy/done handshake.
- Sits on the receive side of the filtered sample stream, for example for loopback checking of the filter.

Parameters:
- b0, 20, current-sample coefficient; must be nonzero.
- b1, 15, coefficient on x[n-1].
- b2, 10, coefficient on x[n-2].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request. Sampled only in IDLE; y_in is captured on the same edge.
- y_in  input  16  unsigned filter output sample.
- x_out  output  8  recovered sample. Holds its value between operations.
- busy  output  1  high from the edge after start is accepted until the done edge.
- done  output  1  one-cycle pulse when x_out and err are updated.
- err  output  1  updated with done. Held until the next done. 1 = y_in is inconsistent with the history.

Behaviour:
- Reset (asynchronous, any state, mid-operation included):
  - x_out=0, busy=0, done=0, err=0.
  - History registers x1=0, x2=0.
  - Working registers cleared; FSM returns to IDLE.
- State IDLE:
  - start=1 captures y_in, asserts busy, goes to CALC.
  - start=0 stays in IDLE.
  - done is low in every cycle except the pulse described under DONE.
- State CALC (1 cycle):
  - num = y_in - b1*x1 - b2*x2, computed as 18-bit signed. Minimum is -6375 with the default coefficients, maximum 65535.
  - If num < 0, set the neg flag and load 0 as the dividend; otherwise load num.
  - Go to DIV with the iteration counter at 15.
- State DIV (16 cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - Divisor is b0; 16-bit quotient q, remainder r.
  - When the counter reaches 0, go to DONE.
- State DONE (1 cycle): register the results, set done=1 and busy=0, then go to IDLE.
  - x_out:
    - 0 if neg.
    - 255 if q > 255.
    - Otherwise q[7:0].
  - err = neg OR (q > 255) OR (r != 0).
  - The history always shifts using the clamped value: x2 <= x1, x1 <= x_out_new.
- Latency: start sampled at edge k gives done=1 during the cycle after edge k+18. Accept rate is one sample per 19 cycles.
  - A new start is accepted at the earliest in the cycle after the done pulse, because the FSM is back in IDLE.
- start while busy: ignored; y_in is not re-captured and the in-flight operation is unaffected.
- start held high: one operation per IDLE visit, so back-to-back operations with no idle gap.
- Arithmetic:
  - Products b1*x1 and b2*x2 are sized at 16 bits.
  - Subtraction is performed in 18-bit signed so that no wrap-around occurs.

Test Plan:
1. Reset, then y_in=200 with start -> after 18 cycles done pulses, x_out=10, err=0, busy is high for exactly 18 cycles.
2. Continue from scenario 1:
   - y_in=230 -> x_out=4, err=0.
   - Then y_in=5260 -> x_out=255, err=0.
3. Continue from scenario 2 (x1=255, x2=4): y_in=100 -> num<0 -> x_out=0, err=1.
   - Then reset and apply y_in=6000 -> q=300 -> x_out=255, err=1.
4. After reset, y_in=205 -> remainder 5 -> x_out=10 (floor), err=1.
   - Then y_in=150 gives num=0 -> x_out=0, err=0, and err clears.
5. Pulse start again at cycle 5 of an operation with a different y_in -> ignored, result unchanged.
   - Hold start high for 3 operations -> done pulses exactly 19 cycles apart.
6. Assert rst asynchronously (between clock edges) during DIV -> outputs and history are 0 immediately and no done pulse follows.
   - After release, y_in=200 -> x_out=10.
